// File: rtl/main_fsm_pkg.sv
// Shared CPU control package: state encoding, opcode constants, ALU operation
// class and datapath select encodings. The ALU control block uses the same
// ALUop encoding, so it lives here rather than in the FSM.
package main_fsm_pkg;

   // Main control FSM states
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECR    = 4'd6,
      ST_EXECI    = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_TRAP     = 4'd11
   } state_t;

   // Instruction opcodes (instruction register bits [6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Operation class handed to the ALU control block
   typedef enum logic [1:0] {
      ALUOP_ADD    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_RTYPE  = 2'b10,
      ALUOP_ITYPE  = 2'b11
   } aluop_t;

   // ALU operand A select
   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RS1   = 2'b10
   } srca_t;

   // ALU operand B select
   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } srcb_t;

   // Result bus select
   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } result_t;

   // Reason the FSM stopped in TRAP
   typedef enum logic [1:0] {
      TRAP_NONE    = 2'b00,
      TRAP_ILLEGAL = 2'b01,
      TRAP_TIMEOUT = 2'b10
   } trap_t;

   // State-only (Moore) part of the control word
   typedef struct packed {
      aluop_t  alu_op;
      srca_t   src_a;
      srcb_t   src_b;
      result_t result_src;
      logic    adr_src;
      logic    mem_req;
      logic    mem_write;
      logic    reg_write;
      logic    pc_write;
      logic    illegal;
   } ctrl_t;

   // Moore control word for a state; anything not listed stays 0.
   // PCWrite/IRWrite in FETCH and PCWrite in BRANCH depend on inputs and are
   // added by the FSM, so only the unconditional JAL PC write appears here.
   function automatic ctrl_t state_ctrl(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.mem_req    = 1'b1;
            c.src_b      = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
         end
         ST_DECODE: begin
            c.src_a = SRCA_OLDPC;
            c.src_b = SRCB_IMM;
         end
         ST_MEMADR: begin
            c.src_a = SRCA_RS1;
            c.src_b = SRCB_IMM;
         end
         ST_MEMREAD: begin
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
         end
         ST_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         // MemWrite qualifies the held store request; memory commits it
         // once, in the cycle it raises mem_ready.
         ST_MEMWRITE: begin
            c.mem_req   = 1'b1;
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         ST_EXECR: begin
            c.src_a  = SRCA_RS1;
            c.src_b  = SRCB_RS2;
            c.alu_op = ALUOP_RTYPE;
         end
         ST_EXECI: begin
            c.src_a  = SRCA_RS1;
            c.src_b  = SRCB_IMM;
            c.alu_op = ALUOP_ITYPE;
         end
         ST_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         ST_BRANCH: begin
            c.src_a      = SRCA_RS1;
            c.src_b      = SRCB_RS2;
            c.alu_op     = ALUOP_BRANCH;
            c.result_src = RES_ALUOUT;
         end
         ST_JAL: begin
            c.src_a      = SRCA_OLDPC;
            c.src_b      = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_write   = 1'b1;
         end
         ST_TRAP: begin
            c.illegal = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   // States that wait on the memory handshake and run the timeout counter
   function automatic logic is_wait_state(state_t s);
      return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
   endfunction

endpackage

// File: rtl/main_fsm_opcode_decode.sv
// Combinational DECODE next-state mapping: selects the instruction class
// path from the opcode, or TRAP for anything unsupported.
module opcode_decode
   import main_fsm_pkg::*;
(
   input  logic [6:0] opcode,
   output logic [3:0] next_state
);

   // Opcode to first execute-phase state
   // NOTE: always_comb gives every output a value before the case so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      next_state = ST_TRAP;
      case (opcode)
         OP_LOAD,
         OP_STORE:  next_state = ST_MEMADR;
         OP_RTYPE:  next_state = ST_EXECR;
         OP_ITYPE:  next_state = ST_EXECI;
         OP_BRANCH: next_state = ST_BRANCH;
         OP_JAL:    next_state = ST_JAL;
         default:   next_state = ST_TRAP;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle CPU main control FSM. Holds the state register, the memory
// wait/timeout counter, the trap cause and the registered Moore control word.
// The few handshake-dependent write enables are added combinationally, and
// every output is forced low while rst is high so a reset can never leak a
// write pulse.
module main_fsm
   import main_fsm_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic [1:0] ALUop,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       AdrSrc,
   output logic       mem_req,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       illegal,
   output logic [1:0] trap_cause
);

   // The cycle that would bring the count to TIMEOUT is the trapping cycle,
   // so a wait state with mem_ready low lasts exactly TIMEOUT cycles.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     next_state;
   trap_t      cause_q;
   trap_t      next_cause;
   ctrl_t      ctrl_q;
   logic [7:0] wait_cnt;
   logic [3:0] decode_next;
   logic       waiting;
   logic       timeout_hit;

   opcode_decode u_opcode_decode (
      .opcode     (opcode),
      .next_state (decode_next)
   );

   assign waiting     = is_wait_state(state) && !mem_ready;
   assign timeout_hit = waiting && (wait_cnt == WAIT_LAST);

   // Next-state and trap-cause selection
   always_comb begin
      next_state = state;
      next_cause = cause_q;
      case (state)
         ST_FETCH: begin
            if (mem_ready) begin
               next_state = ST_DECODE;
            end else if (timeout_hit) begin
               next_state = ST_TRAP;
               next_cause = TRAP_TIMEOUT;
            end
         end
         ST_DECODE: begin
            next_state = state_t'(decode_next);
            if (next_state == ST_TRAP) next_cause = TRAP_ILLEGAL;
         end
         ST_MEMADR:   next_state = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
         ST_MEMREAD: begin
            if (mem_ready) begin
               next_state = ST_MEMWB;
            end else if (timeout_hit) begin
               next_state = ST_TRAP;
               next_cause = TRAP_TIMEOUT;
            end
         end
         ST_MEMWB:    next_state = ST_FETCH;
         ST_MEMWRITE: begin
            if (mem_ready) begin
               next_state = ST_FETCH;
            end else if (timeout_hit) begin
               next_state = ST_TRAP;
               next_cause = TRAP_TIMEOUT;
            end
         end
         ST_EXECR,
         ST_EXECI:    next_state = ST_ALUWB;
         ST_ALUWB:    next_state = ST_FETCH;
         ST_BRANCH:   next_state = ST_FETCH;
         ST_JAL:      next_state = ST_ALUWB;
         ST_TRAP:     next_state = ST_TRAP;
         default:     next_state = ST_FETCH;
      endcase
   end

   // State, Moore control word, trap cause and wait counter registers
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FETCH;
         ctrl_q   <= state_ctrl(ST_FETCH);
         cause_q  <= TRAP_NONE;
         wait_cnt <= 8'd0;
      end else begin
         state   <= next_state;
         ctrl_q  <= state_ctrl(next_state);
         cause_q <= next_cause;
         // Leaving or entering a wait state (or timing out) always clears it
         if (waiting && !timeout_hit) begin
            wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= 8'd0;
         end
      end
   end

   // Output drive: registered Moore word plus handshake-qualified enables,
   // all held low during reset
   always_comb begin
      ALUop      = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      AdrSrc     = 1'b0;
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      illegal    = 1'b0;
      trap_cause = 2'b00;
      if (!rst) begin
         ALUop      = ctrl_q.alu_op;
         ALUSrcA    = ctrl_q.src_a;
         ALUSrcB    = ctrl_q.src_b;
         ResultSrc  = ctrl_q.result_src;
         AdrSrc     = ctrl_q.adr_src;
         mem_req    = ctrl_q.mem_req;
         MemWrite   = ctrl_q.mem_write;
         RegWrite   = ctrl_q.reg_write;
         illegal    = ctrl_q.illegal;
         trap_cause = cause_q;
         IRWrite    = (state == ST_FETCH) && mem_ready;
         PCWrite    = ctrl_q.pc_write
                    || ((state == ST_FETCH) && mem_ready)
                    || ((state == ST_BRANCH) && branch_taken);
      end
   end

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm. A phase-list reference model (each
// instruction class expands to a list of phases, memory phases wait on
// mem_ready with a timeout) predicts every output each cycle.
module tb_main_fsm;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       branch_taken;
   logic [1:0] ALUop, ALUSrcA, ALUSrcB, ResultSrc, trap_cause;
   logic       AdrSrc, mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal;

   main_fsm #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .ALUop        (ALUop),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ResultSrc    (ResultSrc),
      .AdrSrc       (AdrSrc),
      .mem_req      (mem_req),
      .MemWrite     (MemWrite),
      .IRWrite      (IRWrite),
      .PCWrite      (PCWrite),
      .RegWrite     (RegWrite),
      .illegal      (illegal),
      .trap_cause   (trap_cause)
   );

   always #5 clk = ~clk;

   logic [16:0] obs;
   assign obs = {ALUop, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, mem_req, MemWrite,
                 IRWrite, PCWrite, RegWrite, illegal, trap_cause};

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                 P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_TRAP} phase_t;

   phase_t   m_cur = P_FETCH;
   phase_t   m_rest[$];
   int       m_waited = 0;
   bit [1:0] m_cause = 2'b00;

   function automatic logic [16:0] expect_out(phase_t p, bit rdy, bit tk, bit [1:0] cause);
      logic [1:0] aop, sa, sb, rs, tc;
      logic adr, mrq, mw, irw, pcw, rw, ill;
      {aop, sa, sb, rs, tc} = '0;
      {adr, mrq, mw, irw, pcw, rw, ill} = '0;
      case (p)
         P_FETCH:    begin sb = 2; rs = 2; mrq = 1; irw = rdy; pcw = rdy; end
         P_DECODE:   begin sa = 1; sb = 1; end
         P_MEMADR:   begin sa = 2; sb = 1; end
         P_MEMREAD:  begin adr = 1; mrq = 1; end
         P_MEMWB:    begin rs = 1; rw = 1; end
         P_MEMWRITE: begin adr = 1; mrq = 1; mw = 1; end
         P_EXECR:    begin sa = 2; aop = 2; end
         P_EXECI:    begin sa = 2; sb = 1; aop = 3; end
         P_ALUWB:    begin rw = 1; end
         P_BRANCH:   begin sa = 2; aop = 1; pcw = tk; end
         P_JAL:      begin sa = 1; sb = 2; pcw = 1; end
         P_TRAP:     begin ill = 1; tc = cause; end
         default: ;
      endcase
      return {aop, sa, sb, rs, adr, mrq, mw, irw, pcw, rw, ill, tc};
   endfunction

   function automatic phase_t after(phase_t p);
      if (p == P_FETCH) return P_DECODE;
      if (m_rest.size() > 0) return m_rest.pop_front();
      return P_FETCH;
   endfunction

   task automatic model_advance(input bit r, input bit [6:0] op, input bit rdy);
      if (r) begin
         m_cur = P_FETCH; m_rest.delete(); m_waited = 0; m_cause = 2'b00;
         return;
      end
      case (m_cur)
         P_TRAP: ;
         P_FETCH, P_MEMREAD, P_MEMWRITE: begin
            if (rdy) begin
               m_waited = 0;
               m_cur = after(m_cur);
            end else begin
               m_waited++;
               if (m_waited == TO) begin
                  m_cur = P_TRAP; m_cause = 2'b10; m_waited = 0;
               end
            end
         end
         P_DECODE: begin
            m_rest.delete();
            case (op)
               7'b0000011: m_rest = '{P_MEMADR, P_MEMREAD, P_MEMWB};
               7'b0100011: m_rest = '{P_MEMADR, P_MEMWRITE};
               7'b0110011: m_rest = '{P_EXECR, P_ALUWB};
               7'b0010011: m_rest = '{P_EXECI, P_ALUWB};
               7'b1100011: m_rest = '{P_BRANCH};
               7'b1101111: m_rest = '{P_JAL, P_ALUWB};
               default:    m_rest = '{P_TRAP};
            endcase
            m_cur = m_rest.pop_front();
            if (m_cur == P_TRAP) m_cause = 2'b01;
         end
         default: m_cur = after(m_cur);
      endcase
   endtask

   // ---------------- stimulus ----------------
   int rw_seen  = 0;
   int rd_seen  = 0;
   int pcw_seen = 0;

   task automatic step(input string tag, input bit r, input bit [6:0] op,
                       input bit rdy, input bit tk);
      logic [16:0] want;
      rst = r; opcode = op; mem_ready = rdy; branch_taken = tk;
      #3;
      want = r ? 17'd0 : expect_out(m_cur, rdy, tk, m_cause);
      check(tag, int'(obs), int'(want));
      rw_seen  += int'(RegWrite);
      rd_seen  += int'(mem_req && AdrSrc && !MemWrite);
      pcw_seen += int'(PCWrite);
      model_advance(r, op, rdy);
      @(posedge clk); #1;
   endtask

   logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                 7'b0010011, 7'b1100011, 7'b1101111};

   initial begin
      logic [6:0] op;
      rst = 1'b1; opcode = 7'd0; mem_ready = 1'b0; branch_taken = 1'b0;
      @(posedge clk); #1;

      // reset: all outputs low while rst is high
      step("reset0", 1, 7'b0110011, 1, 1);
      step("reset1", 1, 7'b0110011, 0, 0);

      // R-type, zero wait: FETCH DECODE EXECR ALUWB
      rw_seen = 0;
      for (int i = 0; i < 4; i++) step("rtype", 0, 7'b0110011, 1, 0);
      check("rtype_regwrite_pulses", rw_seen, 1);

      // lw with 3 wait cycles in MEMREAD: 8 cycles total
      rd_seen = 0;
      step("lw_fetch", 0, 7'b0000011, 1, 0);
      step("lw_decode", 0, 7'b0000011, 1, 0);
      step("lw_memadr", 0, 7'b0000011, 1, 0);
      for (int i = 0; i < 3; i++) step("lw_wait", 0, 7'b0000011, 0, 0);
      step("lw_memread", 0, 7'b0000011, 1, 0);
      step("lw_memwb", 0, 7'b0000011, 1, 0);
      check("lw_memread_len", rd_seen, 4);
      check("lw_next_fetch_memreq", int'(mem_req), 1);

      // branch taken and not taken
      for (int t = 1; t >= 0; t--) begin
         pcw_seen = 0;
         step("br_fetch", 0, 7'b1100011, 1, 1'(t));
         step("br_decode", 0, 7'b1100011, 1, 1'(t));
         step("br_branch", 0, 7'b1100011, 1, 1'(t));
         check("br_pcwrite_count", pcw_seen, 1 + t);
      end

      // jal then sw
      for (int i = 0; i < 4; i++) step("jal", 0, 7'b1101111, 1, 0);
      for (int i = 0; i < 4; i++) step("sw", 0, 7'b0100011, 1, 0);

      // illegal opcode: sticky trap until reset
      step("ill_fetch", 0, 7'b1110011, 1, 0);
      step("ill_decode", 0, 7'b1110011, 1, 0);
      for (int i = 0; i < 5; i++) step("ill_trap", 0, 7'b1110011, i[0], 1);
      check("ill_cause", int'(trap_cause), 1);
      step("ill_reset", 1, 7'b0110011, 1, 0);

      // FETCH timeout: TO wait cycles then TRAP with cause 10
      for (int i = 0; i < TO + 3; i++) step("to_fetch", 0, 7'b0110011, 0, 0);
      check("to_cause", int'(trap_cause), 2);
      check("to_illegal", int'(illegal), 1);
      step("to_reset", 1, 7'b0110011, 0, 0);

      // handshake on the last allowed wait cycle wins over the timeout
      for (int i = 0; i < TO - 1; i++) step("race_wait", 0, 7'b0110011, 0, 0);
      step("race_ready", 0, 7'b0110011, 1, 0);
      step("race_decode", 0, 7'b0110011, 1, 0);
      check("race_no_trap", int'(illegal), 0);
      step("race_exec", 0, 7'b0110011, 1, 0);
      step("race_wb", 0, 7'b0110011, 1, 0);

      // MEMREAD timeout
      step("lwto_fetch", 0, 7'b0000011, 1, 0);
      step("lwto_decode", 0, 7'b0000011, 1, 0);
      step("lwto_memadr", 0, 7'b0000011, 1, 0);
      for (int i = 0; i < TO + 2; i++) step("lwto_wait", 0, 7'b0000011, 0, 0);
      step("lwto_reset", 1, 7'b0000011, 0, 0);

      // reset during a MEMWRITE wait abandons the store
      step("swr_fetch", 0, 7'b0100011, 1, 0);
      step("swr_decode", 0, 7'b0100011, 1, 0);
      step("swr_memadr", 0, 7'b0100011, 1, 0);
      step("swr_memwrite", 0, 7'b0100011, 0, 0);
      rst = 1'b1; #1;
      check("swr_memwrite_in_rst", int'(MemWrite), 0);
      step("swr_reset", 1, 7'b0100011, 1, 0);
      step("swr_after", 0, 7'b0100011, 0, 0);
      step("swr_reset2", 1, 7'b0100011, 0, 0);

      // randomized run against the model
      op = legal_ops[0];
      for (int n = 0; n < 3000; n++) begin
         bit r, rdy, tk;
         if (m_cur == P_FETCH) begin
            if ($urandom_range(0, 99) < 88) op = legal_ops[$urandom_range(0, 5)];
            else op = 7'($urandom);
         end
         r   = ($urandom_range(0, 99) < 2) || (m_cur == P_TRAP && $urandom_range(0, 9) < 2);
         rdy = ($urandom_range(0, 99) < 75);
         tk  = 1'($urandom);
         step("rand", r, op, rdy, tk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
